bg_vram_writer: RTL and testbench
=================================

Name: bg_vram_writer

Overview:
Write-side companion to the background filler. The CPU issues memory-mapped writes of 3-bit background pixel indices. This block packs three indices into one 9-bit BG vram word and commits the word on the vram write port (port B) with an auto-incrementing address. Packing order matches the filler's unpack order: first pixel in bits [8:6], second in [5:3], third in [2:0].

Parameters:
ADDR_W, 11, vram word-address width; address wraps modulo 2^ADDR_W
PIX_W, 3, bits per packed pixel index; word width = 3*PIX_W = 9

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
mem_enable  input  1  bus select for this block
mem_write  input  1  bus write strobe; a write is accepted when mem_enable && mem_write && ready
reg_sel  input  1  0 = address register, 1 = pixel/data register
write_data  input  16  bus write data
ready  output  1  high when a bus write is accepted this cycle
vram_addr  output  ADDR_W  BG vram port-B address
vram_din  output  9  BG vram port-B write data
vram_we  output  1  BG vram port-B write enable, single-cycle pulse
phase  output  2  current pack slot: 0 = P0, 1 = P1, 2 = P2
words_written  output  16  saturating count of committed words, for debug and test

Behaviour:
- Reset (rst=0 at posedge): phase=P0, vram_addr=0, vram_din=0, vram_we=0, ready=1, words_written=0, pack buffer=0. Reset mid-word discards the partial word and commits nothing.
- All state and outputs are registered. ready = !vram_we, registered.
- Bus writes arriving while ready=0 are dropped with no state change. The bus master must poll ready.
- Address write (reg_sel=0, accepted):
  - vram_addr <= write_data[ADDR_W-1:0], phase <= P0, pack buffer <= 0.
  - Any partial word is discarded.
- Pixel write (reg_sel=1, write_data[15]=0, accepted); pix = write_data[2:0], write_data[14:3] ignored:
  - P0: buf[8:6] <= pix, buf[5:0] <= 0, phase <= P1.
  - P1: buf[5:3] <= pix, phase <= P2.
  - P2: vram_din <= {buf[8:3], pix}, vram_we <= 1 on the next cycle, phase <= P0.
- Flush write (reg_sel=1, write_data[15]=1, accepted):
  - In P1 or P2: vram_din <= buffer with unfilled slots zero, vram_we <= 1, phase <= P0.
  - In P0: no-op, no vram write.
- Commit cycle (vram_we=1), exactly one cycle:
  - vram_addr holds the address being written.
  - On the following edge: vram_we <= 0, vram_addr <= vram_addr+1 (wrapping 2^ADDR_W-1 -> 0), ready <= 1, words_written += 1 (saturating at 16'hFFFF).
- Latency: the pixel that completes a word is accepted on edge N. vram_we is high in cycle N+1. The next write can be accepted on edge N+2.
- The block never reads the vram. The filler owns port A. Same-address read/write collision behaviour is defined by the dual-port RAM (write-first on port B, port A sees the new data one cycle later).
- phase value 3 is illegal. If reached, it recovers to P0 on the next edge.

Test Plan:
- Reset, then addr write 0x000, then pixels 5, 2, 7 -> one vram_we pulse; addr=0x000, din=9'b101_010_111 (0x157); afterwards vram_addr=0x001, words_written=1.
- Addr write 0x7FF, then six pixels 1,1,1,2,2,2 -> commits 0x049 @0x7FF and 0x092 @0x000 (wrap); final vram_addr=0x001.
- Pixels 3, 4, then flush (write_data=0x8000) -> commit din=9'b011_100_000 (0x0E0); phase=P0. A second flush -> no vram_we.
- Pixels 6, 6, then addr write 0x010, then pixels 1, 2, 3 -> only 0x053 written @0x010; the partial 6,6 word is never written.
- Bus write asserted during the commit cycle (ready=0) -> dropped; phase and buffer unchanged, no extra vram_we.
- Pixels 7, 7, then rst=0 for one cycle, then pixels 1, 1, 1 -> single commit 0x049 @0x000; words_written=1.

Source files
------------

// File: rtl/bg_vram_writer.sv
// bg_vram_writer
// Packs CPU-written 3-bit background pixel indices, three per 9-bit word,
// and commits each word to BG vram port B at an auto-incrementing address.
// Packing order: first pixel in the top slot, third pixel in the bottom slot,
// which matches the filler's unpack order.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-low reset
//   mem_enable     bus select for this block
//   mem_write      bus write strobe (accepted with mem_enable && ready)
//   reg_sel        0 = address register, 1 = pixel/data register
//   write_data     bus write data; bit 15 set on a data write means flush
//   ready          high when a bus write can be accepted (registered)
//   vram_addr      port-B word address
//   vram_din       port-B write data
//   vram_we        port-B write enable, one-cycle pulse
//   phase          current pack slot (0..2)
//   words_written  saturating count of committed words
module bg_vram_writer #(
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_enable,
  input  logic                 mem_write,
  input  logic                 reg_sel,
  input  logic [15:0]          write_data,
  output logic                 ready,
  output logic [ADDR_W-1:0]    vram_addr,
  output logic [3*PIX_W-1:0]   vram_din,
  output logic                 vram_we,
  output logic [1:0]           phase,
  output logic [15:0]          words_written
);

  localparam int WORD_W = 3 * PIX_W;

  typedef enum logic [1:0] {
    P0    = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2,
    P_BAD = 2'd3
  } phase_t;

  phase_t              state;
  phase_t              state_next;
  logic [WORD_W-1:0]   pack_buf;
  logic [WORD_W-1:0]   pack_buf_next;
  logic [WORD_W-1:0]   din_next;
  logic [ADDR_W-1:0]   addr_next;
  logic                we_next;
  logic [15:0]         count_next;
  logic                accept;
  logic                is_flush;
  logic [PIX_W-1:0]    pix;

  assign accept   = mem_enable && mem_write && ready;
  assign is_flush = write_data[15];
  assign pix      = write_data[PIX_W-1:0];
  assign phase    = state;

  // State and output registers; everything visible on the ports is a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= P0;
      pack_buf      <= '0;
      vram_din      <= '0;
      vram_addr     <= '0;
      vram_we       <= 1'b0;
      ready         <= 1'b1;
      words_written <= 16'd0;
    end else begin
      state         <= state_next;
      pack_buf      <= pack_buf_next;
      vram_din      <= din_next;
      vram_addr     <= addr_next;
      vram_we       <= we_next;
      // ready mirrors the complement of the write pulse one cycle ahead
      ready         <= !we_next;
      words_written <= count_next;
    end
  end

  // Next-state logic: commit bookkeeping, address loads, pixel packing, flush.
  always_comb begin
    state_next    = state;
    pack_buf_next = pack_buf;
    din_next      = vram_din;
    addr_next     = vram_addr;
    we_next       = 1'b0;
    count_next    = words_written;

    if (vram_we) begin
      // Commit cycle: the word is being written now, advance for the next one.
      addr_next = vram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (words_written == 16'hFFFF) begin
        count_next = words_written;
      end else begin
        count_next = words_written + 16'd1;
      end
    end else if (accept) begin
      if (!reg_sel) begin
        // Address load discards any partially packed word.
        addr_next     = write_data[ADDR_W-1:0];
        state_next    = P0;
        pack_buf_next = '0;
      end else if (is_flush) begin
        case (state)
          P1, P2: begin
            // Unfilled slots are already zero in the buffer.
            din_next      = pack_buf;
            we_next       = 1'b1;
            state_next    = P0;
            pack_buf_next = '0;
          end
          default: begin
            state_next = P0;
          end
        endcase
      end else begin
        case (state)
          P0: begin
            pack_buf_next = {pix, {(2*PIX_W){1'b0}}};
            state_next    = P1;
          end
          P1: begin
            pack_buf_next[2*PIX_W-1:PIX_W] = pix;
            state_next                     = P2;
          end
          P2: begin
            din_next      = {pack_buf[WORD_W-1:PIX_W], pix};
            we_next       = 1'b1;
            state_next    = P0;
            pack_buf_next = '0;
          end
          default: begin
            state_next    = P0;
            pack_buf_next = '0;
          end
        endcase
      end
    end else begin
      state_next = state;
    end

    // The unused encoding always falls back to the first slot.
    if (state == P_BAD) begin
      state_next    = P0;
      pack_buf_next = '0;
    end else begin
      state_next = state_next;
    end
  end

endmodule

// File: tb/tb_bg_vram_writer.sv
// Self-checking bench for bg_vram_writer: a hand-built vector table, directed
// multi-cycle sequences and random bus traffic, all compared cycle by cycle
// against a pixel-queue reference model.
module tb_bg_vram_writer;

  logic        clk;
  logic        rst;
  logic        mem_enable;
  logic        mem_write;
  logic        reg_sel;
  logic [15:0] write_data;
  logic        ready;
  logic [10:0] vram_addr;
  logic [8:0]  vram_din;
  logic        vram_we;
  logic [1:0]  phase;
  logic [15:0] words_written;

  int total = 0;
  int bad   = 0;

  // reference model state
  int pend[$];
  int m_addr = 0;
  int m_din  = 0;
  bit m_we   = 1'b0;
  int m_cnt  = 0;
  int we_seen = 0;

  bg_vram_writer #(.ADDR_W(11), .PIX_W(3)) dut (
    .clk(clk), .rst(rst), .mem_enable(mem_enable), .mem_write(mem_write),
    .reg_sel(reg_sel), .write_data(write_data), .ready(ready),
    .vram_addr(vram_addr), .vram_din(vram_din), .vram_we(vram_we),
    .phase(phase), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit          en;
    bit          wr;
    bit          sel;
    logic [15:0] d;
    int          we;
    int          din;
    int          addr;
    int          ph;
    int          cnt;
    int          rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit en, bit wr, bit sel, logic [15:0] d,
                              int we, int din, int addr, int ph, int cnt, int rdy);
    vec_t v;
    v.r = r; v.en = en; v.wr = wr; v.sel = sel; v.d = d;
    v.we = we; v.din = din; v.addr = addr; v.ph = ph; v.cnt = cnt; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack_word();
    int w = 0;
    foreach (pend[i]) w += pend[i] << (6 - 3 * i);
    return w;
  endfunction

  task automatic model_step(bit r, bit en, bit wr, bit sel, logic [15:0] d);
    if (!r) begin
      pend.delete();
      m_addr = 0; m_din = 0; m_we = 1'b0; m_cnt = 0;
    end else if (m_we) begin
      m_we   = 1'b0;
      m_addr = (m_addr + 1) % 2048;
      if (m_cnt < 65535) m_cnt++;
    end else if (en && wr) begin
      if (!sel) begin
        m_addr = int'(d) % 2048;
        pend.delete();
      end else if (d[15]) begin
        if (pend.size() > 0) begin
          m_din = pack_word();
          pend.delete();
          m_we = 1'b1;
        end
      end else begin
        pend.push_back(int'(d) % 8);
        if (pend.size() == 3) begin
          m_din = pack_word();
          pend.delete();
          m_we = 1'b1;
        end
      end
    end
  endtask

  // one bus cycle: drive on the falling edge, compare 1 ns after the rising edge
  task automatic drive(bit r, bit en, bit wr, bit sel, logic [15:0] d);
    @(negedge clk);
    rst = r; mem_enable = en; mem_write = wr; reg_sel = sel; write_data = d;
    model_step(r, en, wr, sel, d);
    @(posedge clk);
    #1;
    if (vram_we) we_seen++;
    chk("model_we", int'(vram_we), int'(m_we));
    chk("model_ready", int'(ready), int'(!m_we));
    chk("model_phase", int'(phase), pend.size());
    chk("model_addr", int'(vram_addr), m_addr);
    chk("model_din", int'(vram_din), m_din);
    chk("model_count", int'(words_written), m_cnt);
  endtask

  task automatic pixel(int p);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'(p));
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    int w0;
    rst = 1'b0; mem_enable = 1'b0; mem_write = 1'b0; reg_sel = 1'b0; write_data = 16'h0000;

    // ---------------- table-driven vectors ----------------
    vecs.push_back(mk(0,0,0,0,16'h0000, 0,12'h000,12'h000,0,0,1)); // reset
    vecs.push_back(mk(1,1,1,0,16'h0000, 0,12'h000,12'h000,0,0,1)); // addr 0
    vecs.push_back(mk(1,1,1,1,16'h0005, 0,12'h000,12'h000,1,0,1)); // pix 5
    vecs.push_back(mk(1,1,1,1,16'h0002, 0,12'h000,12'h000,2,0,1)); // pix 2
    vecs.push_back(mk(1,1,1,1,16'h0007, 1,12'h157,12'h000,0,0,0)); // pix 7 -> commit
    vecs.push_back(mk(1,0,0,0,16'h0000, 0,12'h157,12'h001,0,1,1)); // after commit
    vecs.push_back(mk(1,1,1,1,16'h7FFB, 0,12'h157,12'h001,1,1,1)); // pix 3, junk high bits
    vecs.push_back(mk(1,1,1,1,16'h0004, 0,12'h157,12'h001,2,1,1)); // pix 4
    vecs.push_back(mk(1,1,1,1,16'h8000, 1,12'h0E0,12'h001,0,1,0)); // flush
    vecs.push_back(mk(1,0,0,0,16'h0000, 0,12'h0E0,12'h002,0,2,1));
    vecs.push_back(mk(1,1,1,1,16'h8000, 0,12'h0E0,12'h002,0,2,1)); // flush in P0: no-op
    vecs.push_back(mk(1,1,1,1,16'h0006, 0,12'h0E0,12'h002,1,2,1)); // pix 6
    vecs.push_back(mk(1,1,1,1,16'h0006, 0,12'h0E0,12'h002,2,2,1)); // pix 6
    vecs.push_back(mk(1,1,1,0,16'h0010, 0,12'h0E0,12'h010,0,2,1)); // addr 0x010 discards
    vecs.push_back(mk(1,1,1,1,16'h0001, 0,12'h0E0,12'h010,1,2,1));
    vecs.push_back(mk(1,1,1,1,16'h0002, 0,12'h0E0,12'h010,2,2,1));
    vecs.push_back(mk(1,1,1,1,16'h0003, 1,12'h053,12'h010,0,2,0)); // commit 0x053
    vecs.push_back(mk(1,0,0,0,16'h0000, 0,12'h053,12'h011,0,3,1));
    vecs.push_back(mk(1,0,1,1,16'h0005, 0,12'h053,12'h011,0,3,1)); // strobe without enable

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].en, vecs[i].wr, vecs[i].sel, vecs[i].d);
      chk($sformatf("tbl%0d_we", i), int'(vram_we), vecs[i].we);
      chk($sformatf("tbl%0d_din", i), int'(vram_din), vecs[i].din);
      chk($sformatf("tbl%0d_addr", i), int'(vram_addr), vecs[i].addr);
      chk($sformatf("tbl%0d_phase", i), int'(phase), vecs[i].ph);
      chk($sformatf("tbl%0d_count", i), int'(words_written), vecs[i].cnt);
      chk($sformatf("tbl%0d_ready", i), int'(ready), vecs[i].rdy);
    end

    // ---------------- address wrap ----------------
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h07FF);
    pixel(1); pixel(1); pixel(1);
    chk("wrap_we0", int'(vram_we), 1);
    chk("wrap_addr0", int'(vram_addr), 12'h7FF);
    chk("wrap_din0", int'(vram_din), 12'h049);
    idle();
    pixel(2); pixel(2); pixel(2);
    chk("wrap_we1", int'(vram_we), 1);
    chk("wrap_addr1", int'(vram_addr), 12'h000);
    chk("wrap_din1", int'(vram_din), 12'h092);
    idle();
    chk("wrap_final_addr", int'(vram_addr), 12'h001);

    // ---------------- write during commit is dropped ----------------
    pixel(4); pixel(4); pixel(4);
    chk("drop_ready_low", int'(ready), 0);
    w0 = we_seen;
    pixel(5);                       // offered while ready=0
    chk("drop_phase", int'(phase), 0);
    idle(); idle();
    chk("drop_no_extra_we", we_seen, w0);
    pixel(3);
    chk("drop_buffer_clear_phase", int'(phase), 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h8000);
    chk("drop_flush_din", int'(vram_din), 12'h0C0);
    idle();

    // ---------------- reset mid-word ----------------
    pixel(7); pixel(7);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_phase", int'(phase), 0);
    chk("rst_count", int'(words_written), 0);
    w0 = we_seen;
    pixel(1); pixel(1); pixel(1);
    chk("rst_commit_addr", int'(vram_addr), 0);
    chk("rst_commit_din", int'(vram_din), 12'h049);
    idle();
    chk("rst_single_commit", we_seen - w0, 1);
    chk("rst_count_after", int'(words_written), 1);

    // ---------------- random traffic vs. model ----------------
    for (int n = 0; n < 600; n++) begin
      bit          en;
      bit          wr;
      bit          sel;
      logic [15:0] d;
      en  = ($urandom_range(0, 9) != 0);
      wr  = ($urandom_range(0, 9) != 0);
      sel = ($urandom_range(0, 11) != 0);
      d   = 16'($urandom);
      if ($urandom_range(0, 5) != 0) d[15] = 1'b0;
      drive(($urandom_range(0, 199) != 0), en, wr, sel, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
